// File: rtl/lane_renderer_if.sv
// Pixel-stream bundle between a lane renderer and whoever requests redraws.
// The master requests redraws and consumes the pixel stream; the renderer is the slave.
interface lane_renderer_if;
    logic        start;
    logic [15:0] lane;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, lane,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, lane,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/lane_renderer.sv
// Redraws one 4-pixel-wide note lane (16 slots of SLOT_H rows) into a VGA adapter.
// Optional macro LANE_RENDERER_HIT_ZONE_EN adds a white two-row hit bar under the lane.
module lane_renderer #(
    parameter logic [7:0] X_BASE      = 8'd76,
    parameter int         SLOT_H      = 7,
    parameter logic [2:0] NOTE_COLOUR = 3'b010
) (
    input  logic clk,
    input  logic resetn,
    lane_renderer_if.slave bus
);

    localparam logic [6:0] DRAW_ROWS = 7'(16 * SLOT_H);
    localparam logic [2:0] ROW_LAST  = 3'(SLOT_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
`ifdef LANE_RENDERER_HIT_ZONE_EN
        HIT  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [1:0]  col, col_n;
    logic [2:0]  row_in, row_in_n;
    logic [3:0]  slot, slot_n;
    logic [6:0]  y_pos, y_pos_n;
    logic [15:0] snapshot, snapshot_n;
`ifdef LANE_RENDERER_HIT_ZONE_EN
    logic [2:0]  hit_cnt, hit_cnt_n;
`endif

    logic [7:0]  x_q, x_n;
    logic [6:0]  y_q, y_n;
    logic [2:0]  colour_q, colour_n;
    logic        plot_q, plot_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;

    logic        last_pixel;

    assign last_pixel = (col == 2'd3) && (row_in == ROW_LAST) && (slot == 4'd15);

    // Outputs are registered from the next-cycle values so the first pixel lands one cycle after start.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            col      <= '0;
            row_in   <= '0;
            slot     <= '0;
            y_pos    <= '0;
            snapshot <= '0;
`ifdef LANE_RENDERER_HIT_ZONE_EN
            hit_cnt  <= '0;
`endif
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row_in   <= row_in_n;
            slot     <= slot_n;
            y_pos    <= y_pos_n;
            snapshot <= snapshot_n;
`ifdef LANE_RENDERER_HIT_ZONE_EN
            hit_cnt  <= hit_cnt_n;
`endif
            x_q      <= x_n;
            y_q      <= y_n;
            colour_q <= colour_n;
            plot_q   <= plot_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        col_n      = col;
        row_in_n   = row_in;
        slot_n     = slot;
        y_pos_n    = y_pos;
        snapshot_n = snapshot;
`ifdef LANE_RENDERER_HIT_ZONE_EN
        hit_cnt_n  = hit_cnt;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n    = DRAW;
                    col_n      = '0;
                    row_in_n   = '0;
                    slot_n     = '0;
                    y_pos_n    = '0;
                    snapshot_n = bus.lane;
                end
            end
            DRAW: begin
                col_n = col + 2'd1;
                if (last_pixel) begin
`ifdef LANE_RENDERER_HIT_ZONE_EN
                    state_n   = HIT;
                    y_pos_n   = DRAW_ROWS;
                    hit_cnt_n = '0;
`else
                    state_n   = DONE;
`endif
                end else if (col == 2'd3) begin
                    // Row-in-slot counter replaces a divide by SLOT_H.
                    y_pos_n = y_pos + 7'd1;
                    if (row_in == ROW_LAST) begin
                        row_in_n = '0;
                        slot_n   = slot + 4'd1;
                    end else begin
                        row_in_n = row_in + 3'd1;
                    end
                end
            end
`ifdef LANE_RENDERER_HIT_ZONE_EN
            HIT: begin
                if (hit_cnt == 3'd7) begin
                    state_n = DONE;
                end else begin
                    hit_cnt_n = hit_cnt + 3'd1;
                    col_n     = col + 2'd1;
                    if (col == 2'd3) begin
                        y_pos_n = y_pos + 7'd1;
                    end
                end
            end
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        x_n      = x_q;
        y_n      = y_q;
        colour_n = colour_q;
        plot_n   = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        case (state_n)
            DRAW: begin
                plot_n   = 1'b1;
                busy_n   = 1'b1;
                x_n      = X_BASE + {6'd0, col_n};
                y_n      = y_pos_n;
                colour_n = snapshot_n[4'd15 - slot_n] ? NOTE_COLOUR : 3'b000;
            end
`ifdef LANE_RENDERER_HIT_ZONE_EN
            HIT: begin
                plot_n   = 1'b1;
                busy_n   = 1'b1;
                x_n      = X_BASE + {6'd0, col_n};
                y_n      = y_pos_n;
                colour_n = 3'b111;
            end
`endif
            DONE: begin
                busy_n = 1'b1;
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_lane_renderer.sv
// Self-checking bench for lane_renderer against a per-cycle pixel model of a redraw.
module tb_lane_renderer;

    localparam int SLOT_H   = 7;
    localparam int X_BASE   = 76;
    localparam int DRAW_CYC = 64 * SLOT_H;
`ifdef LANE_RENDERER_HIT_ZONE_EN
    localparam int HIT_CYC  = 8;
`else
    localparam int HIT_CYC  = 0;
`endif
    localparam int PLOTS    = DRAW_CYC + HIT_CYC;
    localparam int DONE_AT  = PLOTS + 1;

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #10 clk = ~clk;

    lane_renderer_if bus ();

    lane_renderer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    function automatic obs_t observed();
        return obs_t'({bus.plot, bus.x, bus.y, bus.colour, bus.busy, bus.done});
    endfunction

    // Expected outputs in cycle c of a redraw (c=1 is the cycle after start is accepted).
    function automatic obs_t expected_at(input logic [15:0] snap, input int c);
        obs_t e;
        int   i;
        int   row;
        e = '0;
        if (c >= 1 && c <= DRAW_CYC) begin
            i        = c - 1;
            row      = i / 4;
            e.plot   = 1'b1;
            e.busy   = 1'b1;
            e.x      = 8'(X_BASE + i % 4);
            e.y      = 7'(row);
            e.colour = snap[15 - row / SLOT_H] ? 3'b010 : 3'b000;
        end else if (c > DRAW_CYC && c <= PLOTS) begin
            i        = c - DRAW_CYC - 1;
            e.plot   = 1'b1;
            e.busy   = 1'b1;
            e.x      = 8'(X_BASE + i % 4);
            e.y      = 7'(16 * SLOT_H + i / 4);
            e.colour = 3'b111;
        end else begin
            e.x = 8'(X_BASE + 3);
            if (HIT_CYC > 0) begin
                e.y      = 7'(16 * SLOT_H + 1);
                e.colour = 3'b111;
            end else begin
                e.y      = 7'(16 * SLOT_H - 1);
                e.colour = snap[0] ? 3'b010 : 3'b000;
            end
            if (c == DONE_AT) begin
                e.busy = 1'b1;
                e.done = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_redraw(input logic [15:0] pat);
        bus.lane  = pat;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.lane  = 16'hFFFF;
        resetn    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (observed() !== obs_t'(0)) begin
                bad++;
                $display("[TB] FAIL reset_state k=%0d got=%h want=%h", k, observed(), obs_t'(0));
            end
        end
        bus.start = 1'b0;
        resetn    = 1'b1;
        tick();
        total++;
        if (observed() !== obs_t'(0)) begin
            bad++;
            $display("[TB] FAIL idle_after_reset got=%h want=%h", observed(), obs_t'(0));
        end
    endtask

    task automatic test_patterns();
        logic [15:0] pats [7];
        int          plots;
        obs_t        got;
        obs_t        exp;
        pats[0] = 16'h0001;
        pats[1] = 16'h8000;
        pats[2] = 16'hFFFF;
        pats[3] = 16'h0000;
        for (int p = 4; p < 7; p++) pats[p] = 16'($urandom);
        for (int p = 0; p < 7; p++) begin
            start_redraw(pats[p]);
            plots = 0;
            for (int c = 1; c <= DONE_AT + 2; c++) begin
                got = observed();
                exp = expected_at(pats[p], c);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("[TB] FAIL pattern lane=%h c=%0d got=%h want=%h", pats[p], c, got, exp);
                end
                if (got.plot === 1'b1) plots++;
                tick();
            end
            total++;
            if (plots != PLOTS) begin
                bad++;
                $display("[TB] FAIL plot_count lane=%h got=%0d want=%0d", pats[p], plots, PLOTS);
            end
        end
    endtask

    task automatic test_snapshot_hold();
        obs_t got;
        obs_t exp;
        start_redraw(16'hFFFF);
        for (int c = 1; c <= DONE_AT + 1; c++) begin
            got = observed();
            exp = expected_at(16'hFFFF, c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL snapshot_hold c=%0d got=%h want=%h", c, got, exp);
            end
            if (c == 5) bus.lane = 16'h0000;
            else if (c > 5) bus.lane = 16'($urandom);
            tick();
        end
    endtask

    task automatic test_ignored_start();
        logic [15:0] pat;
        int          dones;
        obs_t        got;
        obs_t        exp;
        pat = 16'($urandom);
        start_redraw(pat);
        dones = 0;
        for (int c = 1; c <= DONE_AT + 3; c++) begin
            got = observed();
            exp = expected_at(pat, c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL ignored_start c=%0d got=%h want=%h", c, got, exp);
            end
            if (got.done === 1'b1) dones++;
            bus.start = (c == 10 || c == 200 || c == DONE_AT);
            bus.lane  = 16'($urandom);
            tick();
        end
        bus.start = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("[TB] FAIL done_pulses got=%0d want=1", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] pat;
        logic [15:0] pat2;
        obs_t        got;
        obs_t        exp;
        pat  = 16'($urandom);
        pat2 = 16'($urandom);
        start_redraw(pat);
        for (int c = 1; c <= 100; c++) begin
            got = observed();
            exp = expected_at(pat, c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL pre_abort c=%0d got=%h want=%h", c, got, exp);
            end
            if (c == 100) resetn = 1'b0;
            tick();
        end
        total++;
        if (observed() !== obs_t'(0)) begin
            bad++;
            $display("[TB] FAIL abort_state got=%h want=%h", observed(), obs_t'(0));
        end
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (observed() !== obs_t'(0)) begin
                bad++;
                $display("[TB] FAIL post_abort_idle k=%0d got=%h want=%h", k, observed(), obs_t'(0));
            end
        end
        start_redraw(pat2);
        for (int c = 1; c <= DONE_AT + 1; c++) begin
            got = observed();
            exp = expected_at(pat2, c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL redraw_after_abort c=%0d got=%h want=%h", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        logic [15:0] pat2;
        int          plots;
        obs_t        got;
        obs_t        exp;
        pat  = 16'($urandom);
        pat2 = ~pat;
        start_redraw(pat);
        for (int c = 1; c <= DONE_AT + 1; c++) begin
            got = observed();
            exp = expected_at(pat, c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL first_of_pair c=%0d got=%h want=%h", c, got, exp);
            end
            if (c <= DONE_AT) tick();
        end
        start_redraw(pat2);
        plots = 0;
        for (int c = 1; c <= DONE_AT + 1; c++) begin
            got = observed();
            exp = expected_at(pat2, c);
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL second_of_pair c=%0d got=%h want=%h", c, got, exp);
            end
            if (got.plot === 1'b1) plots++;
            tick();
        end
        total++;
        if (plots != PLOTS) begin
            bad++;
            $display("[TB] FAIL back_to_back_plots got=%0d want=%0d", plots, PLOTS);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.lane  = 16'h0000;
        test_reset();
        test_patterns();
        test_snapshot_hold();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_renderer.md
LANE_RENDERER -- requirements
Module: lane_renderer

Interface
REQ-001 The block SHALL take parameter X_BASE, default 8'd76, as the leftmost pixel column of the lane.
REQ-002 The block SHALL take parameter SLOT_H, default 7, as the pixel rows per note slot; the legal range is 1..7.
REQ-003 The block SHALL take parameter NOTE_COLOUR, default 3'b010, as the RGB colour of a present note.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock at 50 MHz, all logic on posedge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to redraw the lane.
REQ-007 The block SHALL have port lane, input, 16 bits: note pattern; lane[0] is the hit position (bottom), lane[15] is the top.
REQ-008 The block SHALL have port x, output, 8 bits: pixel column to the VGA adapter.
REQ-009 The block SHALL have port y, output, 7 bits: pixel row to the VGA adapter.
REQ-010 The block SHALL have port colour, output, 3 bits: pixel colour to the VGA adapter.
REQ-011 The block SHALL have port plot, output, 1 bit: write-enable for the current x/y/colour.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a redraw is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a redraw completes.

Function
REQ-014 The FSM SHALL have states IDLE, DRAW, HIT and DONE, and all outputs SHALL be registered.
REQ-015 In IDLE, start=1 SHALL latch lane into a snapshot register and move to DRAW on the next cycle; start SHALL be ignored in all other states.
REQ-016 The snapshot SHALL NOT change during a redraw; changes on lane after acceptance SHALL have no effect until the next accepted start.
REQ-017 DRAW SHALL scan rows y = 0..16*SLOT_H-1 as the outer loop and columns x = X_BASE..X_BASE+3 as the inner loop, one pixel per cycle with plot=1.
REQ-018 The slot index SHALL come from a 4-bit slot counter plus a row-in-slot counter (0..SLOT_H-1), with no divider; the row y falls in slot s = y div SLOT_H.
REQ-019 The colour in DRAW SHALL be NOTE_COLOUR when snapshot[15-s]=1, else 3'b000.
REQ-020 The first DRAW pixel (X_BASE, 0) SHALL appear with plot=1 in the cycle after start is accepted.
REQ-021 DRAW SHALL last exactly 64*SLOT_H cycles (448 with the defaults).
REQ-022 After the last DRAW pixel the FSM SHALL go to HIT when the macro is defined (REQ-032), else directly to DONE.
REQ-023 In DONE, done=1 and plot=0 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-024 busy SHALL be 1 in DRAW, HIT and DONE, and 0 in IDLE.
REQ-025 A start in the same cycle as done=1 SHALL be ignored.
REQ-026 A start in the first IDLE cycle after DONE SHALL be accepted.
REQ-027 In IDLE, plot SHALL be 0; x, y and colour SHALL hold their last values.
REQ-028 x SHALL never leave X_BASE..X_BASE+3, and y SHALL never exceed 16*SLOT_H+1.

Reset
REQ-029 resetn=0 at a clock edge SHALL force IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0, snapshot=0, all counters=0.
REQ-030 Reset asserted mid-redraw SHALL abort the redraw with no done pulse; the next accepted start SHALL redraw from (X_BASE, 0).
REQ-031 start SHALL be ignored while resetn=0.

Configuration
REQ-032 With LANE_RENDERER_HIT_ZONE_EN defined, HIT SHALL draw rows 16*SLOT_H and 16*SLOT_H+1 across columns X_BASE..X_BASE+3 in 3'b111, for 8 cycles with plot=1, before DONE.
REQ-033 Without LANE_RENDERER_HIT_ZONE_EN, the HIT state and its logic SHALL be absent, and the done pulse SHALL occur 449 cycles after start acceptance (defaults).
REQ-034 With LANE_RENDERER_HIT_ZONE_EN defined, the done pulse SHALL occur 457 cycles after start acceptance (defaults).

Verification
REQ-035 Defaults, macro off, lane=16'h0001, start pulse: expect 448 plots; rows 0..104 colour 000; rows 105..111 colour 010; done at cycle 449.
REQ-036 lane=16'h8000, macro on: expect rows 0..6 colour 010; rows 112..113 colour 111 at x=76..79; done at cycle 457; total plots 456.
REQ-037 Start accepted with lane=16'hFFFF, lane driven to 0 at cycle 5: every DRAW pixel is 010 (snapshot held).
REQ-038 Start pulses at cycles 10 and 200 during a redraw: only one redraw occurs; exactly one done pulse.
REQ-039 resetn=0 at cycle 100 of DRAW: next cycle plot=0, busy=0, x=0, y=0, and no done; a new start then yields a first pixel at (76, 0).
REQ-040 Back-to-back: start again in the cycle after done: accepted; the second redraw has the identical plot count.
